// File: rtl/sonar_posicao_servo.sv
// sonar_posicao_servo: sweep position, servo PWM and angle-to-ASCII converter.
// The sweep ping-pongs between 0 and N_POS-1 by default. Defining
// SERVO_SWEEP_WRAP_EN switches it to a sawtooth (N_POS-1 wraps to 0).
// The angle digits come from repeated subtraction. angulo_pronto is low while
// a conversion is in flight, and the digit outputs only change when a result
// is published.
module sonar_posicao_servo #(
  parameter int PWM_PERIOD = 1000000,
  parameter int PULSE_MIN  = 50000,
  parameter int PULSE_STEP = 7142,
  parameter int N_POS      = 8,
  parameter int ANGLE_STEP = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       zera,
  input  logic       conta,
  output logic       pwm,
  output logic [3:0] posicao,
  output logic [6:0] angulo_centena,
  output logic [6:0] angulo_dezena,
  output logic [6:0] angulo_unidade,
  output logic       angulo_pronto,
  output logic       db_sentido
);
  localparam int         CW      = $clog2(PWM_PERIOD + 1);
  localparam logic [3:0] POS_MAX = 4'(N_POS - 1);

  typedef enum logic [1:0] {OCIOSO, CENTENA, DEZENA} conv_t;

  logic          sentido, sentido_nxt;
  logic [3:0]    pos_nxt;
  logic          upd;
  logic [CW-1:0] cnt, largura, largura_pos;
  conv_t         state, state_nxt;
  logic [9:0]    resto, angulo_nxt;
  logic [3:0]    cen, dez;

  // Any strobe moves the sweep and restarts the converter.
  assign upd         = zera | conta;
  assign db_sentido  = sentido;
  assign largura_pos = CW'(PULSE_MIN) + CW'(posicao) * CW'(PULSE_STEP);
  assign angulo_nxt  = 10'(pos_nxt) * 10'(ANGLE_STEP);

  // Next sweep position and direction. zera has priority over conta.
  always_comb begin
    pos_nxt     = posicao;
    sentido_nxt = sentido;
    if (zera) begin
      pos_nxt     = 4'd0;
      sentido_nxt = 1'b1;
    end else if (conta) begin
`ifdef SERVO_SWEEP_WRAP_EN
      sentido_nxt = 1'b1;
      pos_nxt     = (posicao == POS_MAX) ? 4'd0 : posicao + 4'd1;
`else
      if (sentido) begin
        if (posicao < POS_MAX) pos_nxt = posicao + 4'd1;
        else begin
          pos_nxt     = POS_MAX - 4'd1;
          sentido_nxt = 1'b0;
        end
      end else begin
        if (posicao != 4'd0) pos_nxt = posicao - 4'd1;
        else begin
          pos_nxt     = 4'd1;
          sentido_nxt = 1'b1;
        end
      end
`endif
    end
  end

  // Sweep position/direction registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      posicao <= 4'd0;
      sentido <= 1'b1;
    end else begin
      posicao <= pos_nxt;
      sentido <= sentido_nxt;
    end
  end

  // PWM counter. The new width is taken only at the period wrap, so a pulse
  // is never cut short. zera restarts the period at the minimum width.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      largura <= CW'(PULSE_MIN);
      pwm     <= 1'b0;
    end else begin
      pwm <= (cnt < largura);
      if (zera) begin
        cnt     <= '0;
        largura <= CW'(PULSE_MIN);
      end else if (cnt == CW'(PWM_PERIOD - 1)) begin
        cnt     <= '0;
        largura <= largura_pos;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Converter state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= OCIOSO;
    else          state <= state_nxt;
  end

  // Converter next state. A strobe always (re)starts the conversion.
  always_comb begin
    state_nxt = state;
    case (state)
      CENTENA: if (resto < 10'd100) state_nxt = DEZENA;
      DEZENA:  if (resto < 10'd10)  state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
    if (upd) state_nxt = CENTENA;
  end

  // Converter datapath. The digits are published together when the tens
  // digit is done, so a partial result is never visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resto          <= '0;
      cen            <= '0;
      dez            <= '0;
      angulo_centena <= 7'h30;
      angulo_dezena  <= 7'h30;
      angulo_unidade <= 7'h30;
      angulo_pronto  <= 1'b1;
    end else if (upd) begin
      resto         <= angulo_nxt;
      cen           <= '0;
      dez           <= '0;
      angulo_pronto <= 1'b0;
    end else begin
      case (state)
        CENTENA: begin
          if (resto >= 10'd100) begin
            resto <= resto - 10'd100;
            cen   <= cen + 4'd1;
          end
        end
        DEZENA: begin
          if (resto >= 10'd10) begin
            resto <= resto - 10'd10;
            dez   <= dez + 4'd1;
          end else begin
            angulo_centena <= 7'h30 + 7'(cen);
            angulo_dezena  <= 7'h30 + 7'(dez);
            angulo_unidade <= 7'h30 + 7'(resto);
            angulo_pronto  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_posicao_servo.sv
// Bench for sonar_posicao_servo. A behavioural model tracks the sweep, the PWM
// period and the conversion window. A negedge compare process checks every
// cycle, and directed steps pin the literal expectations.
module tb_sonar_posicao_servo;
  localparam int PER  = 100;
  localparam int MIN  = 5;
  localparam int STEP = 5;
  localparam int NP   = 8;
  localparam int ASTP = 20;

  logic       clock, reset_n, zera, conta;
  logic       pwm, angulo_pronto, db_sentido;
  logic [3:0] posicao;
  logic [6:0] angulo_centena, angulo_dezena, angulo_unidade;

  int checks = 0;
  int errors = 0;

  sonar_posicao_servo #(
    .PWM_PERIOD(PER), .PULSE_MIN(MIN), .PULSE_STEP(STEP), .N_POS(NP), .ANGLE_STEP(ASTP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .zera(zera), .conta(conta),
    .pwm(pwm), .posicao(posicao),
    .angulo_centena(angulo_centena), .angulo_dezena(angulo_dezena),
    .angulo_unidade(angulo_unidade), .angulo_pronto(angulo_pronto),
    .db_sentido(db_sentido)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ASCII digit k (2 = hundreds, 1 = tens, 0 = units) of angle a
  function automatic int dig(input int a, input int k);
    case (k)
      2:       return 48 + a / 100;
      1:       return 48 + (a / 10) % 10;
      default: return 48 + a % 10;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int m_pos, m_dir, m_cnt, m_w, e_pwm, m_since;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pos <= 0; m_dir <= 1; m_cnt <= 0; m_w <= MIN; e_pwm <= 0; m_since <= 100;
    end else begin
      e_pwm <= (m_cnt < m_w) ? 1 : 0;
      if (zera) begin
        m_cnt <= 0; m_w <= MIN;
      end else if (m_cnt == PER - 1) begin
        m_cnt <= 0; m_w <= MIN + m_pos * STEP;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (zera || conta) m_since <= 0;
      else if (m_since < 100) m_since <= m_since + 1;
      if (zera) begin
        m_pos <= 0; m_dir <= 1;
      end else if (conta) begin
`ifdef SERVO_SWEEP_WRAP_EN
        m_pos <= (m_pos + 1) % NP;
`else
        if (m_dir == 1) begin
          if (m_pos < NP - 1) m_pos <= m_pos + 1;
          else begin m_pos <= NP - 2; m_dir <= 0; end
        end else begin
          if (m_pos > 0) m_pos <= m_pos - 1;
          else begin m_pos <= 1; m_dir <= 1; end
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int pub_c = 48, pub_d = 48, pub_u = 48;

  always @(negedge clock) begin
    if (!reset_n) begin
      pub_c = 48; pub_d = 48; pub_u = 48;
    end else begin
      chk("posicao", posicao, m_pos);
      chk("db_sentido", db_sentido, m_dir);
      chk("pwm", pwm, e_pwm);
      if (m_since == 0) chk("pronto_drop", angulo_pronto, 0);
      if (angulo_pronto) begin
        chk("centena", angulo_centena, dig(m_pos * ASTP, 2));
        chk("dezena", angulo_dezena, dig(m_pos * ASTP, 1));
        chk("unidade", angulo_unidade, dig(m_pos * ASTP, 0));
        pub_c = angulo_centena; pub_d = angulo_dezena; pub_u = angulo_unidade;
      end else begin
        chk("stale_centena", angulo_centena, pub_c);
        chk("stale_dezena", angulo_dezena, pub_d);
        chk("stale_unidade", angulo_unidade, pub_u);
        if (m_since > 20) chk("conv_latency", m_since, 20);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input logic z, input logic c);
    @(negedge clock); zera = z; conta = c;
    @(negedge clock); zera = 0; conta = 0;
  endtask

  task automatic wait_pronto();
    int n = 0;
    while (!angulo_pronto && n < 25) begin
      @(negedge clock); n++;
    end
    chk("pronto_timeout", angulo_pronto, 1);
  endtask

  task automatic count_pwm(output int h);
    h = 0;
    repeat (PER) begin @(negedge clock); h += pwm; end
  endtask

  task automatic goto_up(input int p);
    for (int k = 0; k < 40 && !(m_pos == p && m_dir == 1); k++) strobe(0, 1);
    chk("goto_pos", posicao, p);
  endtask

  task automatic chk_digits(input string name, input int c, input int d, input int u);
    chk({name, "_c"}, angulo_centena, c);
    chk({name, "_d"}, angulo_dezena, d);
    chk({name, "_u"}, angulo_unidade, u);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int h;
    clock = 0; reset_n = 0; zera = 0; conta = 0;
    repeat (3) @(negedge clock);
    chk("rst_pwm", pwm, 0);
    chk("rst_pos", posicao, 0);
    chk("rst_sentido", db_sentido, 1);
    chk("rst_pronto", angulo_pronto, 1);
    chk_digits("rst", 8'h30, 8'h30, 8'h30);
    reset_n = 1;

    repeat (50) @(negedge clock);
    count_pwm(h);
    chk("pwm_width_pos0", h, 5);

    for (int i = 1; i <= 7; i++) begin
      strobe(0, 1);
      chk("sweep_pos", posicao, i);
      if (i == 7) begin
        chk("pronto_low_140", angulo_pronto, 0);
        wait_pronto();
        chk_digits("dig_140", 8'h31, 8'h34, 8'h30);
      end
      repeat (28) @(negedge clock);
    end
    repeat (100) @(negedge clock);
    count_pwm(h);
    chk("pwm_width_pos7", h, 40);

`ifdef SERVO_SWEEP_WRAP_EN
    strobe(0, 1);
    chk("wrap_pos", posicao, 0);
    chk("wrap_sentido", db_sentido, 1);
    wait_pronto();
    chk_digits("wrap_000", 8'h30, 8'h30, 8'h30);
`else
    strobe(0, 1);
    chk("turn_pos", posicao, 6);
    chk("turn_sentido", db_sentido, 0);
    for (int i = 0; i < 6; i++) begin strobe(0, 1); repeat (5) @(negedge clock); end
    chk("bottom_pos", posicao, 0);
    strobe(0, 1);
    chk("bounce_pos", posicao, 1);
    chk("bounce_sentido", db_sentido, 1);
`endif
    repeat (10) @(negedge clock);

    // restart mid-conversion: 60 must never be published
    goto_up(2);
    repeat (10) @(negedge clock);
    strobe(0, 1);
    @(negedge clock);
    strobe(0, 1);
    chk("abort_pos", posicao, 4);
    chk("abort_pronto", angulo_pronto, 0);
    wait_pronto();
    chk_digits("dig_080", 8'h30, 8'h38, 8'h30);

    // zera wins over conta
    goto_up(5);
    repeat (10) @(negedge clock);
    strobe(1, 1);
    chk("zera_pos", posicao, 0);
    chk("zera_sentido", db_sentido, 1);
    @(negedge clock);
    chk("zera_pwm_start", pwm, 1);
    h = pwm;
    repeat (PER - 1) begin @(negedge clock); h += pwm; end
    chk("zera_pwm_width", h, 5);
    chk_digits("zera_000", 8'h30, 8'h30, 8'h30);

    // random strobes against the model
    repeat (600) begin
      @(negedge clock);
      zera  = ($urandom_range(0, 39) == 0);
      conta = ($urandom_range(0, 7) == 0);
    end
    @(negedge clock); zera = 0; conta = 0;
    repeat (30) @(negedge clock);

    // async reset during a pulse and a conversion
    strobe(1, 0);
    strobe(0, 1);
    chk("pre_rst_pwm", pwm, 1);
    chk("pre_rst_pronto", angulo_pronto, 0);
    @(posedge clock); #2 reset_n = 0;
    #1;
    chk("async_rst_pwm", pwm, 0);
    chk("async_rst_pos", posicao, 0);
    chk("async_rst_pronto", angulo_pronto, 1);
    chk_digits("async_rst", 8'h30, 8'h30, 8'h30);
    @(negedge clock); @(negedge clock);
    reset_n = 1;
    repeat (20) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sonar_posicao_servo.md
Name: sonar_posicao_servo

Overview:
Position/actuation stage directly upstream of the sonar control unit. It holds the current sweep position, drives the servo PWM, and converts the current angle into three ASCII digits. The control unit transmits those digits (centena/dezena/unidade of the angle) and advances the sweep via its zera_posicao/conta_posicao strobes. Angle-to-ASCII conversion is sequential and is flagged by angulo_pronto.

Parameters:
PWM_PERIOD, 1000000, PWM period in clock cycles (20 ms at 50 MHz)
PULSE_MIN, 50000, pulse width in cycles at position 0 (1 ms)
PULSE_STEP, 7142, pulse width increment per position
N_POS, 8, number of sweep positions (2..16)
ANGLE_STEP, 20, degrees per position; N_POS-1 times ANGLE_STEP must not exceed 999

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
zera  in  1  sync strobe: return to position 0, sweep upward
conta  in  1  sync strobe: advance one position along the sweep
pwm  out  1  servo PWM, registered
posicao  out  4  current position index
angulo_centena  out  7  ASCII hundreds digit of the angle
angulo_dezena  out  7  ASCII tens digit
angulo_unidade  out  7  ASCII units digit
angulo_pronto  out  1  high when the digits match the current posicao
db_sentido  out  1  sweep direction, 1 = up

Behaviour:
- Reset (reset_n low, async): posicao=0, sentido=1, PWM counter=0, largura=PULSE_MIN, pwm=0, digits=0x30 each, angulo_pronto=1, converter OCIOSO.
- Sweep (default ping-pong): on conta with sentido=1: if posicao<N_POS-1 then posicao+1, else posicao=N_POS-2 and sentido=0. With sentido=0: if posicao>0 then posicao-1, else posicao=1 and sentido=1. Update lands on the clock edge that samples conta.
- zera: posicao=0, sentido=1, PWM counter=0, largura=PULSE_MIN loaded immediately. zera and conta in the same cycle: zera wins, conta is ignored.
- PWM: counter runs 0..PWM_PERIOD-1 and wraps.
  - pwm registered as (counter < largura_ativa).
  - largura_ativa = PULSE_MIN + posicao*PULSE_STEP. It is loaded only when the counter reaches PWM_PERIOD-1 (no runt pulses), except on zera.
- Angle: angulo = posicao*ANGLE_STEP, 10 bits unsigned.
- Converter FSM: OCIOSO -> CENTENA -> DEZENA -> OCIOSO.
  - Start: the cycle after any posicao update (conta or zera), resto=angulo, digit counters=0, angulo_pronto=0.
  - CENTENA: while resto>=100, resto-=100 and centena+1 per cycle; else go to DEZENA.
  - DEZENA: while resto>=10, resto-=10 and dezena+1 per cycle; else unidade=resto, publish the three digits as 0x30+digit, angulo_pronto=1, go to OCIOSO.
  - Latency = 2 + (hundreds) + (tens) cycles after the start cycle; at most 20.
  - Digit outputs hold their old value until publish; no partial values are ever visible.
- A new conta/zera during conversion aborts the conversion and restarts it with the new angle. angulo_pronto stays 0.
- reset_n asserted mid-conversion or mid-pulse: immediate return to reset values.

Optional Feature:
SERVO_SWEEP_WRAP_EN
- Defined: sawtooth sweep. conta at posicao=N_POS-1 wraps to 0, sentido is held at 1, and db_sentido is constantly 1.
- Undefined: ping-pong sweep as described in Behaviour.

Test Plan:
Bench parameters: PWM_PERIOD=100, PULSE_MIN=5, PULSE_STEP=5, N_POS=8, ANGLE_STEP=20.
- Reset, then release -> posicao=0, pwm high exactly 5 of every 100 cycles, digits "000", angulo_pronto=1.
- 7 conta strobes 30 cycles apart -> posicao 1..7. After the 7th: angulo_pronto low, then high within 20 cycles with digits "140" (0x31,0x34,0x30). PWM pulse becomes 40 cycles starting at the next period boundary.
- 8th conta -> posicao=6, db_sentido=0. Continue to posicao=0, then one more conta -> posicao=1, db_sentido=1.
- conta at posicao=3 two cycles after a prior conta (mid-conversion) -> digits go directly to "080" with no "060"; angulo_pronto is 1 only after the final result.
- zera and conta asserted together at posicao=5 -> posicao=0, sentido=1, pwm pulse 5 cycles starting from a counter of 0, digits "000".
- With SERVO_SWEEP_WRAP_EN: conta at posicao=7 -> posicao=0, db_sentido=1, digits "000".
